// File: rtl/mesm6_alu_ctl.sv
`default_nettype none
// ============================================================================
//  mesm6_alu_ctl : valid/ready sequencer that feeds one request at a time to
//  mesm6_alu, captures the result and issues a clearing NOP after each op.
//  Revision: 1.0
// ============================================================================

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP {`ALU_OP_WIDTH{1'b0}}
`endif

module mesm6_alu_ctl #(
    parameter int TIMEOUT = 63
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [`ALU_OP_WIDTH-1:0] req_op_i,
    input  logic                     req_wy_i,
    input  logic                     req_grp_log_i,
    input  logic                     req_norm_i,
    input  logic                     req_round_i,
    input  logic [47:0]              req_a_i,
    input  logic [47:0]              req_b_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [47:0]              rsp_acc_o,
    output logic                     rsp_err_o,
    output logic [5:0]               rsp_cycles_o,
    output logic [`ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                     alu_wy_o,
    output logic                     alu_grp_log_o,
    output logic                     alu_do_norm_o,
    output logic                     alu_do_round_o,
    output logic [47:0]              alu_a_o,
    output logic [47:0]              alu_b_o,
    input  logic [47:0]              alu_acc_i,
    input  logic                     alu_done_i
);

    localparam logic [`ALU_OP_WIDTH-1:0] OP_NOP = `ALU_NOP;
    localparam logic [5:0] TIMEOUT_C = TIMEOUT[5:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WY    = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]               state_q,     state_d;
    logic [`ALU_OP_WIDTH-1:0] op_q,        op_d;
    logic                     wy_q,        wy_d;
    logic                     grp_q,       grp_d;
    logic                     norm_q,      norm_d;
    logic                     round_q,     round_d;
    logic [47:0]              a_q,         a_d;
    logic [47:0]              b_q,         b_d;
    logic [5:0]               cnt_q,       cnt_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [47:0]              rsp_acc_q,   rsp_acc_d;
    logic                     rsp_err_q,   rsp_err_d;
    logic [5:0]               rsp_cycles_q, rsp_cycles_d;

    logic       accept_w;
    logic [5:0] cnt_inc_w;
    logic [5:0] cnt_sat_w;

    assign req_ready_o = (state_q == S_IDLE) && (!rsp_valid_q || rsp_ready_i);
    assign accept_w    = req_valid_i && req_ready_o;
    assign cnt_inc_w   = cnt_q + 6'd1;
    assign cnt_sat_w   = (cnt_q == 6'd63) ? cnt_q : cnt_inc_w;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wy_d         = wy_q;
        grp_d        = grp_q;
        norm_d       = norm_q;
        round_d      = round_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_acc_d    = rsp_acc_q;
        rsp_err_d    = rsp_err_q;
        rsp_cycles_d = rsp_cycles_q;

        if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_w) begin
                    op_d    = req_op_i;
                    grp_d   = req_grp_log_i;
                    norm_d  = req_norm_i;
                    round_d = req_round_i;
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    cnt_d   = 6'd0;
                    if (req_op_i == OP_NOP) begin
                        wy_d    = req_wy_i;
                        state_d = S_WY;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_WY: begin
                wy_d         = 1'b0;
                rsp_acc_d    = a_q;
                rsp_err_d    = 1'b0;
                rsp_cycles_d = 6'd0;
                rsp_valid_d  = 1'b1;
                state_d      = S_IDLE;
            end
            S_RUN: begin
                cnt_d = cnt_sat_w;
                // The first RUN edge only launches the op, so cnt_q equals
                // the number of ALU cycles by the time done is seen.
                if (alu_done_i) begin
                    rsp_acc_d    = alu_acc_i;
                    rsp_err_d    = 1'b0;
                    rsp_cycles_d = cnt_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_DRAIN;
                end else if (cnt_inc_w == TIMEOUT_C) begin
                    rsp_acc_d    = 48'd0;
                    rsp_err_d    = 1'b1;
                    rsp_cycles_d = TIMEOUT_C;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NOP;
            wy_q         <= 1'b0;
            grp_q        <= 1'b0;
            norm_q       <= 1'b0;
            round_q      <= 1'b0;
            a_q          <= 48'd0;
            b_q          <= 48'd0;
            cnt_q        <= 6'd0;
            rsp_valid_q  <= 1'b0;
            rsp_acc_q    <= 48'd0;
            rsp_err_q    <= 1'b0;
            rsp_cycles_q <= 6'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wy_q         <= wy_d;
            grp_q        <= grp_d;
            norm_q       <= norm_d;
            round_q      <= round_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_acc_q    <= rsp_acc_d;
            rsp_err_q    <= rsp_err_d;
            rsp_cycles_q <= rsp_cycles_d;
        end
    end

    // Outside RUN the ALU always sees NOP, which also clears a stale done.
    assign alu_op_o       = (state_q == S_RUN) ? op_q : OP_NOP;
    assign alu_wy_o       = wy_q;
    assign alu_grp_log_o  = grp_q;
    assign alu_do_norm_o  = norm_q;
    assign alu_do_round_o = round_q;
    assign alu_a_o        = a_q;
    assign alu_b_o        = b_q;

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_acc_o    = rsp_acc_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_cycles_o = rsp_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_mesm6_alu_ctl.sv
`default_nettype none
// ============================================================================
//  tb_mesm6_alu_ctl : directed bench with a small behavioural ALU model.
//  Revision: 1.0
// ============================================================================

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif

module tb_mesm6_alu_ctl;

    localparam int TO = 8;
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_AAX  = 6'd1;
    localparam logic [5:0] OP_ARX  = 6'd2;
    localparam logic [5:0] OP_YTA  = 6'd3;
    localparam logic [5:0] OP_FDIV = 6'd4;
    localparam logic [5:0] OP_HANG = 6'd5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_wy, req_grp, req_norm, req_round;
    logic [5:0]  req_op;
    logic [47:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [47:0] rsp_acc;
    logic [5:0]  rsp_cycles;
    logic [5:0]  alu_op;
    logic        alu_wy, alu_grp, alu_norm, alu_round;
    logic [47:0] alu_a, alu_b, alu_acc;
    logic        alu_done;

    always #5 clk = ~clk;

    mesm6_alu_ctl #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_wy_i(req_wy), .req_grp_log_i(req_grp),
        .req_norm_i(req_norm), .req_round_i(req_round),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_acc_o(rsp_acc), .rsp_err_o(rsp_err), .rsp_cycles_o(rsp_cycles),
        .alu_op_o(alu_op), .alu_wy_o(alu_wy), .alu_grp_log_o(alu_grp),
        .alu_do_norm_o(alu_norm), .alu_do_round_o(alu_round),
        .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_acc_i(alu_acc), .alu_done_i(alu_done)
    );

    // ---------------- behavioural ALU ----------------
    logic [47:0] m_acc, m_y;
    logic        m_done;
    int          m_cnt;

    function automatic int lat(input logic [5:0] op);
        case (op)
            OP_AAX:  return 1;
            OP_ARX:  return 2;
            OP_YTA:  return 1;
            OP_FDIV: return 20;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [47:0] res(input logic [5:0] op, input logic [47:0] a,
                                        input logic [47:0] b, input logic [47:0] y);
        logic [48:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            OP_AAX:  return a & b;
            OP_ARX:  return s[47:0] + {47'd0, s[48]};
            OP_YTA:  return y;
            default: return 48'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_done <= 1'b0; m_cnt <= 0; m_acc <= 48'd0; m_y <= 48'd0;
        end else if (alu_op == OP_NOP) begin
            m_done <= 1'b0; m_cnt <= 0;
            if (alu_wy) m_y <= alu_a;
        end else if (!m_done) begin
            if (m_cnt + 1 == lat(alu_op)) begin
                m_done <= 1'b1;
                m_acc  <= res(alu_op, alu_a, alu_b, m_y);
            end
            m_cnt <= m_cnt + 1;
        end
    end
    assign alu_done = m_done;
    assign alu_acc  = m_acc;

    // ---------------- checking ----------------
    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("req_ready_wait", 0, 1);
    endtask

    task automatic drive(input logic [5:0] op, input logic wy, input logic grp,
                         input logic nrm, input logic rnd,
                         input logic [47:0] a, input logic [47:0] b);
        req_valid = 1'b1; req_op = op; req_wy = wy; req_grp = grp;
        req_norm = nrm; req_round = rnd; req_a = a; req_b = b;
    endtask

    task automatic send(input logic [5:0] op, input logic wy, input logic grp,
                        input logic [47:0] a, input logic [47:0] b);
        wait_ready();
        drive(op, wy, grp, 1'b0, 1'b0, a, b);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic recv(input string nm, input logic [47:0] acc, input logic err,
                        input logic [5:0] cyc);
        int n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk({nm, "_valid"}, {63'd0, rsp_valid}, 64'd1);
        chk({nm, "_acc"}, {16'd0, rsp_acc}, {16'd0, acc});
        chk({nm, "_err"}, {63'd0, rsp_err}, {63'd0, err});
        chk({nm, "_cycles"}, {58'd0, rsp_cycles}, {58'd0, cyc});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [5:0]  op;
        logic        wy;
        logic        grp;
        logic [47:0] a;
        logic [47:0] b;
        logic [47:0] acc;
        logic        err;
        logic [5:0]  cyc;
    } vec_t;

    vec_t vt [8];

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vt[0] = '{OP_AAX,  1'b0, 1'b0, 48'hFFFF_0000_FFFF, 48'h0F0F_0F0F_0F0F, 48'h0F0F_0000_0F0F, 1'b0, 6'd1};
        vt[1] = '{OP_ARX,  1'b0, 1'b0, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 48'h0000_0000_0001, 1'b0, 6'd2};
        vt[2] = '{OP_AAX,  1'b0, 1'b0, 48'h1234_5678_9ABC, 48'hFFFF_FF00_0000, 48'h1234_5600_0000, 1'b0, 6'd1};
        vt[3] = '{OP_ARX,  1'b0, 1'b0, 48'h0000_0000_0005, 48'h0000_0000_0007, 48'h0000_0000_000C, 1'b0, 6'd2};
        vt[4] = '{OP_NOP,  1'b1, 1'b0, 48'h1234_5678_9ABC, 48'h0,              48'h1234_5678_9ABC, 1'b0, 6'd0};
        vt[5] = '{OP_YTA,  1'b0, 1'b1, 48'h0,              48'h0,              48'h1234_5678_9ABC, 1'b0, 6'd1};
        vt[6] = '{OP_HANG, 1'b0, 1'b0, 48'hDEAD_BEEF_0001, 48'h1,              48'h0,              1'b1, 6'd8};
        vt[7] = '{OP_AAX,  1'b0, 1'b0, 48'hAAAA_AAAA_AAAA, 48'h5555_5555_FFFF, 48'h0000_0000_AAAA, 1'b0, 6'd1};

        reset_n = 1'b0; rsp_ready = 1'b0;
        drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 48'd0, 48'd0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid",  {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_acc",    {16'd0, rsp_acc}, 64'd0);
        chk("rst_rsp_err",    {63'd0, rsp_err}, 64'd0);
        chk("rst_rsp_cycles", {58'd0, rsp_cycles}, 64'd0);
        chk("rst_alu_op",     {58'd0, alu_op}, {58'd0, OP_NOP});
        chk("rst_alu_modes",  {60'd0, alu_wy, alu_grp, alu_norm, alu_round}, 64'd0);
        chk("rst_alu_ab",     {alu_a[31:0], alu_b[31:0]}, 64'd0);
        reset_n = 1'b1;

        // Latency of a one-cycle ALU op, edge by edge
        @(negedge clk);
        drive(OP_AAX, 1'b0, 1'b0, 1'b0, 1'b0, 48'hFFFF_0000_FFFF, 48'h0F0F_0F0F_0F0F);
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat_e0_op",    {58'd0, alu_op}, {58'd0, OP_AAX});
        chk("lat_e0_a",     {16'd0, alu_a}, 64'h0000_FFFF_0000_FFFF);
        chk("lat_e0_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        chk("lat_e1_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        chk("lat_e2_valid", {63'd0, rsp_valid}, 64'd1);
        chk("lat_e2_acc",   {16'd0, rsp_acc}, 64'h0000_0F0F_0000_0F0F);
        chk("lat_e2_cyc",   {58'd0, rsp_cycles}, 64'd1);
        chk("lat_e2_nop",   {58'd0, alu_op}, {58'd0, OP_NOP});
        chk("lat_e2_ready", {63'd0, req_ready}, 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("lat_e3_ready", {63'd0, req_ready}, 64'd1);
        chk("lat_e3_valid", {63'd0, rsp_valid}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            send(vt[i].op, vt[i].wy, vt[i].grp, vt[i].a, vt[i].b);
            recv($sformatf("vec%0d", i), vt[i].acc, vt[i].err, vt[i].cyc);
        end

        // Y write pulse is exactly one cycle, then YTA reads it back
        wait_ready();
        drive(OP_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 48'hCAFE_0000_BEEF, 48'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wy_pulse_hi", {63'd0, alu_wy}, 64'd1);
        chk("wy_op_nop",   {58'd0, alu_op}, {58'd0, OP_NOP});
        @(negedge clk);
        chk("wy_pulse_lo", {63'd0, alu_wy}, 64'd0);
        recv("wy", 48'hCAFE_0000_BEEF, 1'b0, 6'd0);
        send(OP_YTA, 1'b0, 1'b1, 48'd0, 48'd0);
        recv("yta", 48'hCAFE_0000_BEEF, 1'b0, 6'd1);

        // Back-pressure with a request waiting, then same-cycle handover
        send(OP_AAX, 1'b0, 1'b0, 48'h0000_FFFF_FFFF, 48'h0F0F_0F0F_0000);
        repeat (2) @(negedge clk);
        drive(OP_ARX, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0000_0000_0005, 48'h0000_0000_0007);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_acc",   {16'd0, rsp_acc}, 64'h0000_0000_0F0F_0000);
            chk("bp_ready", {63'd0, req_ready}, 64'd0);
            chk("bp_no_run", {58'd0, alu_op}, {58'd0, OP_NOP});
        end
        rsp_ready = 1'b1;
        #1;
        chk("ho_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk("ho_valid_clr", {63'd0, rsp_valid}, 64'd0);
        chk("ho_op_run",    {58'd0, alu_op}, {58'd0, OP_ARX});
        recv("ho", 48'h0000_0000_000C, 1'b0, 6'd2);

        // Asynchronous reset in the middle of a long FDIV
        wait_ready();
        drive(OP_FDIV, 1'b0, 1'b1, 1'b1, 1'b1, 48'h0000_0000_0064, 48'h0000_0000_0005);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("fdiv_run",  {58'd0, alu_op}, {58'd0, OP_FDIV});
        chk("fdiv_mode", {61'd0, alu_grp, alu_norm, alu_round}, 64'd7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_op",    {58'd0, alu_op}, {58'd0, OP_NOP});
        chk("mrst_ready", {63'd0, req_ready}, 64'd1);
        chk("mrst_rsp",   {rsp_valid, rsp_err, rsp_cycles, 8'd0, rsp_acc}, 64'd0);
        chk("mrst_alu",   {alu_a[27:0], alu_b[27:0], 4'd0, alu_grp, alu_norm, alu_round, alu_wy}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send(OP_AAX, 1'b0, 1'b0, 48'hFFFF_0000_FFFF, 48'h0F0F_0F0F_0F0F);
        recv("post_rst", 48'h0F0F_0000_0F0F, 1'b0, 6'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
